// File: rtl/counter_updown_mod.sv
// counter_updown_mod
// ------------------
// Parametrised synchronous up/down counter with parallel load, modulo-N
// wrap, 74161/74191-style cascade enables, a combinational terminal-count
// output and a one-shot mode that stops at the terminal value.
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MODULUS  count modulus; 0 selects the natural 2^WIDTH range,
//            otherwise 2..2^WIDTH. MAX is MODULUS-1 (or all ones).
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   load     synchronous parallel load, active-high
//   preset   load value (not range-checked)
//   cep      parallel count enable (does not gate tc)
//   cet      trickle/cascade count enable (gates tc)
//   up       direction: 1 = increment, 0 = decrement
//   oneshot  1 = hold at the terminal value instead of wrapping
//   counter  registered count value
//   tc       combinational terminal count, feeds the next stage's cet
//   done     registered sticky flag: one-shot terminal reached

module counter_updown_mod #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    input  logic             cep,
    input  logic             cet,
    input  logic             up,
    input  logic             oneshot,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = (MODULUS == 0) ? {WIDTH{1'b1}}
                                                      : WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic             above_max;
    logic             term;
    logic             cnt_en;
    logic [WIDTH-1:0] step;

    assign at_max  = (counter == MAX);
    assign at_zero = (counter == '0);

    // Values above MAX only exist after loading an out-of-range preset.
    // In the natural-modulus case nothing can exceed MAX, so the compare
    // is dropped rather than left as a constant-false expression.
    generate
        if (MODULUS == 0) begin : g_natural
            assign above_max = 1'b0;
        end else begin : g_modulo
            assign above_max = (counter > MAX);
        end
    endgenerate

    assign term   = up ? at_max : at_zero;
    assign tc     = cet & term;
    assign cnt_en = cep & cet & ~load;

    // Wrap-mode successor. Out-of-range values are pulled back into the
    // range in the counting direction: 0 when counting up, MAX when down.
    always_comb begin
        step = counter;
        if (up) begin
            step = (at_max || above_max) ? '0 : counter + ONE;
        end else begin
            step = (at_zero || above_max) ? MAX : counter - ONE;
        end
    end

    // Priority: reset, then load, then count, otherwise hold. In one-shot
    // mode the edge that would step past the terminal value holds instead
    // and latches done, which stays set until reset or load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            counter <= '0;
            done    <= 1'b0;
        end else if (load) begin
            counter <= preset;
            done    <= 1'b0;
        end else if (cnt_en) begin
            if (oneshot && term) begin
                done <= 1'b1;
            end else begin
                counter <= step;
            end
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod
// ---------------------
// Self-checking bench for counter_updown_mod. Four channels are exercised
// side by side:
//   ch0  WIDTH=8, MODULUS=10
//   ch1  WIDTH=4, MODULUS=0
//   ch2  WIDTH=8, MODULUS=0
//   ch3  two WIDTH=4 stages cascaded (tc of the low stage drives cet of
//        the high stage), modelled as a single 8-bit counter
// A behavioural model tracks each channel with plain modular arithmetic
// and a compare process checks every output on every falling edge.
// Directed sequences pin the model with literal expectations, then a long
// randomized run follows.

module tb_counter_updown_mod;

    localparam int MODN [4] = '{10, 16, 256, 256};
    localparam int MASK [4] = '{255, 15, 255, 255};

    logic       clk;
    logic       rst;
    logic       ld   [4];
    logic [7:0] pre  [4];
    logic       cep  [4];
    logic       cet  [4];
    logic       up   [4];
    logic       os   [4];

    logic [7:0] cnt0;
    logic       tc0;
    logic       done0;
    logic [3:0] cnt1;
    logic       tc1;
    logic       done1;
    logic [7:0] cnt2;
    logic       tc2;
    logic       done2;
    logic [3:0] cnt_l;
    logic       tc_l;
    logic       done_l;
    logic [3:0] cnt_h;
    logic       tc_h;
    logic       done_h;

    int m_cnt  [4];
    bit m_done [4];
    bit armed;
    int total;
    int bad;

    counter_updown_mod #(.WIDTH(8), .MODULUS(10)) dut0 (
        .clk(clk), .rst(rst), .load(ld[0]), .preset(pre[0]),
        .cep(cep[0]), .cet(cet[0]), .up(up[0]), .oneshot(os[0]),
        .counter(cnt0), .tc(tc0), .done(done0)
    );

    counter_updown_mod #(.WIDTH(4), .MODULUS(0)) dut1 (
        .clk(clk), .rst(rst), .load(ld[1]), .preset(pre[1][3:0]),
        .cep(cep[1]), .cet(cet[1]), .up(up[1]), .oneshot(os[1]),
        .counter(cnt1), .tc(tc1), .done(done1)
    );

    counter_updown_mod #(.WIDTH(8), .MODULUS(0)) dut2 (
        .clk(clk), .rst(rst), .load(ld[2]), .preset(pre[2]),
        .cep(cep[2]), .cet(cet[2]), .up(up[2]), .oneshot(os[2]),
        .counter(cnt2), .tc(tc2), .done(done2)
    );

    counter_updown_mod #(.WIDTH(4), .MODULUS(0)) dut_lo (
        .clk(clk), .rst(rst), .load(ld[3]), .preset(pre[3][3:0]),
        .cep(cep[3]), .cet(cet[3]), .up(up[3]), .oneshot(1'b0),
        .counter(cnt_l), .tc(tc_l), .done(done_l)
    );

    counter_updown_mod #(.WIDTH(4), .MODULUS(0)) dut_hi (
        .clk(clk), .rst(rst), .load(ld[3]), .preset(pre[3][7:4]),
        .cep(cep[3]), .cet(tc_l), .up(up[3]), .oneshot(1'b0),
        .counter(cnt_h), .tc(tc_h), .done(done_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Terminal value of a channel in its current direction.
    function automatic bit model_term(input int c);
        if (up[c]) return m_cnt[c] == MODN[c] - 1;
        return m_cnt[c] == 0;
    endfunction

    // Next value in wrap mode: modular step inside the range, snap to the
    // range edge in the counting direction when outside it.
    function automatic int model_next(input int c);
        int n;
        int v;
        n = MODN[c];
        v = m_cnt[c];
        if (up[c]) return (v < n) ? (v + 1) % n : 0;
        return (v < n) ? (v + n - 1) % n : n - 1;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (!rst) begin
                m_cnt[c]  <= 0;
                m_done[c] <= 1'b0;
            end else if (ld[c]) begin
                m_cnt[c]  <= int'(pre[c]) & MASK[c];
                m_done[c] <= 1'b0;
            end else if (cep[c] && cet[c]) begin
                if (c != 3 && os[c] && model_term(c)) m_done[c] <= 1'b1;
                else m_cnt[c] <= model_next(c);
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, got, want);
        end
    endtask

    // Continuous comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("ch0 counter", int'(cnt0), m_cnt[0]);
            checkOutput("ch0 tc", int'(tc0), int'(cet[0] && model_term(0)));
            checkOutput("ch0 done", int'(done0), int'(m_done[0]));
            checkOutput("ch1 counter", int'(cnt1), m_cnt[1]);
            checkOutput("ch1 tc", int'(tc1), int'(cet[1] && model_term(1)));
            checkOutput("ch1 done", int'(done1), int'(m_done[1]));
            checkOutput("ch2 counter", int'(cnt2), m_cnt[2]);
            checkOutput("ch2 tc", int'(tc2), int'(cet[2] && model_term(2)));
            checkOutput("ch2 done", int'(done2), int'(m_done[2]));
            checkOutput("cascade counter", int'({cnt_h, cnt_l}), m_cnt[3]);
            checkOutput("cascade tc_lo", int'(tc_l),
                        int'(cet[3] && (up[3] ? (m_cnt[3] % 16 == 15) : (m_cnt[3] % 16 == 0))));
            checkOutput("cascade tc_hi", int'(tc_h), int'(cet[3] && model_term(3)));
            checkOutput("cascade done", int'(done_l | done_h), 0);
        end
    end

    // Advance one edge; inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_ch(input int c, input int value);
        ld[c]  = 1'b1;
        pre[c] = 8'(value);
        tick();
        ld[c]  = 1'b0;
    endtask

    task automatic applyStimulus();
        rst = ($urandom_range(63) != 0);
        for (int c = 0; c < 4; c++) begin
            ld[c]  = ($urandom_range(7) == 0);
            pre[c] = 8'($urandom_range(255));
            cep[c] = ($urandom_range(3) != 0);
            cet[c] = ($urandom_range(3) != 0);
            up[c]  = 1'($urandom_range(1));
            os[c]  = ($urandom_range(2) == 0);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        armed = 1'b0;
        rst   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ld[c] = 1'b0; pre[c] = 8'h00; cep[c] = 1'b0;
            cet[c] = 1'b0; up[c] = 1'b0; os[c] = 1'b0;
        end
        tick();
        armed = 1'b1;
        checkOutput("reset counter", int'(cnt2), 0);
        checkOutput("reset done", int'(done2), 0);
        rst = 1'b1;

        // Reset beats load.
        load_ch(2, 8'h37);
        checkOutput("load 0x37", int'(cnt2), 8'h37);
        rst = 1'b0; ld[2] = 1'b1; pre[2] = 8'hAA;
        tick();
        checkOutput("rst over load counter", int'(cnt2), 0);
        checkOutput("rst over load done", int'(done2), 0);
        rst = 1'b1;
        tick();
        ld[2] = 1'b0;
        checkOutput("load after rst", int'(cnt2), 8'hAA);

        // Modulo-10 wrap up, then down through zero.
        load_ch(0, 0);
        cep[0] = 1'b1; cet[0] = 1'b1; up[0] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checkOutput("mod10 up counter", int'(cnt0), i % 10);
            checkOutput("mod10 up tc", int'(tc0), int'(i % 10 == 9));
        end
        up[0] = 1'b0;
        tick();
        checkOutput("mod10 down to 0", int'(cnt0), 0);
        checkOutput("mod10 down tc", int'(tc0), 1);
        tick();
        checkOutput("mod10 down wrap", int'(cnt0), 9);
        tick();
        checkOutput("mod10 down 8", int'(cnt0), 8);

        // Enable gating at MAX.
        cep[0] = 1'b0; up[0] = 1'b1;
        load_ch(0, 9);
        tick();
        checkOutput("cep=0 hold", int'(cnt0), 9);
        checkOutput("cep=0 tc", int'(tc0), 1);
        cet[0] = 1'b0;
        #1;
        checkOutput("cet=0 tc", int'(tc0), 0);
        tick();
        checkOutput("cet=0 hold", int'(cnt0), 9);

        // Out-of-range load pulls back into range.
        load_ch(0, 12);
        cep[0] = 1'b1; cet[0] = 1'b1; up[0] = 1'b1;
        tick();
        checkOutput("oor up", int'(cnt0), 0);
        load_ch(0, 12);
        up[0] = 1'b0;
        tick();
        checkOutput("oor down", int'(cnt0), 9);
        cep[0] = 1'b0; cet[0] = 1'b0;

        // Cascade of two 4-bit stages.
        load_ch(3, 8'h0E);
        cep[3] = 1'b1; cet[3] = 1'b1; up[3] = 1'b1;
        tick();
        checkOutput("cascade 0x0F", int'({cnt_h, cnt_l}), 8'h0F);
        checkOutput("cascade tc_hi low", int'(tc_h), 0);
        tick();
        checkOutput("cascade 0x10", int'({cnt_h, cnt_l}), 8'h10);
        tick();
        checkOutput("cascade 0x11", int'({cnt_h, cnt_l}), 8'h11);
        load_ch(3, 8'hFE);
        tick();
        checkOutput("cascade 0xFF", int'({cnt_h, cnt_l}), 8'hFF);
        checkOutput("cascade tc_hi at 0xFF", int'(tc_h), 1);
        tick();
        checkOutput("cascade wrap", int'({cnt_h, cnt_l}), 0);
        cep[3] = 1'b0; cet[3] = 1'b0;

        // One-shot stop at 15.
        os[1] = 1'b1;
        load_ch(1, 13);
        cep[1] = 1'b1; cet[1] = 1'b1; up[1] = 1'b1;
        tick();
        checkOutput("oneshot 14", int'(cnt1), 14);
        tick();
        checkOutput("oneshot 15", int'(cnt1), 15);
        checkOutput("oneshot done early", int'(done1), 0);
        tick();
        checkOutput("oneshot hold", int'(cnt1), 15);
        checkOutput("oneshot done set", int'(done1), 1);
        tick();
        checkOutput("oneshot still 15", int'(cnt1), 15);
        checkOutput("oneshot done sticky", int'(done1), 1);
        load_ch(1, 3);
        checkOutput("oneshot reload", int'(cnt1), 3);
        checkOutput("oneshot reload done", int'(done1), 0);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) applyStimulus();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) ld[c] = 1'b0;
        tick();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
